// File: rtl/iiitb_sdm_pkg.sv
// Shared constants for the programmable serial sequence detector family.
package iiitb_sdm_pkg;

    // Pattern the original fixed detector looked for; default reset pattern.
    localparam logic [3:0] SDM_PAT_1010 = 4'b1010;

    // Widest pattern window supported by the detector.
    localparam int SDM_PAT_W_MAX = 32;

    // Matching modes carried on the overlap input.
    localparam logic SDM_MODE_OVERLAP = 1'b1;
    localparam logic SDM_MODE_NONOVL  = 1'b0;

    typedef enum logic {
        MODE_NONOVL  = SDM_MODE_NONOVL,
        MODE_OVERLAP = SDM_MODE_OVERLAP
    } sdm_mode_e;

endpackage

// File: rtl/iiitb_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module iiitb_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // Count up on inc, stick at all-ones, clear has priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/iiitb_sdm_param.sv
// Programmable, maskable serial sequence detector with overlap control,
// saturating match counter and sticky match flag.
module iiitb_sdm_param
    import iiitb_sdm_pkg::*;
#(
    parameter int               PAT_W    = 4,
    parameter int               CNT_W    = 8,
    parameter logic [PAT_W-1:0] RST_PAT  = PAT_W'(SDM_PAT_1010),
    parameter logic [PAT_W-1:0] RST_MASK = {PAT_W{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_vld,
    input  logic             pat_ld,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [PAT_W-1:0] mask_in,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             sticky,
    output logic             busy
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  history;
    logic [PAT_W-1:0]  pattern;
    logic [PAT_W-1:0]  mask;
    logic [FILL_W-1:0] fill;

    logic [PAT_W-1:0]  history_next;
    logic [FILL_W-1:0] fill_inc;
    logic              sample;
    logic              hit;
    sdm_mode_e         mode;

    // A load cycle swallows any valid bit presented with it.
    assign sample = din_vld && !pat_ld;
    assign mode   = sdm_mode_e'(overlap);

    // Next-state window and match decision, evaluated on post-shift values.
    always_comb begin
        history_next = history;
        fill_inc     = fill;
        hit          = 1'b0;
        if (sample) begin
            history_next = {history[PAT_W-2:0], din};
            fill_inc     = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
            hit          = (fill_inc == FILL_FULL) &&
                           (((history_next ^ pattern) & mask) == '0);
        end
    end

    // Window state: pattern/mask load, shift history, track fill level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            history <= '0;
            fill    <= '0;
            pattern <= RST_PAT;
            mask    <= RST_MASK;
        end else if (pat_ld) begin
            pattern <= pat_in;
            mask    <= mask_in;
            fill    <= '0;
        end else if (sample) begin
            history <= history_next;
            // Non-overlapping mode keeps history but demands a fresh window.
            if (hit && (mode == MODE_NONOVL))
                fill <= '0;
            else
                fill <= fill_inc;
        end
    end

    // Registered match pulse and sticky flag; clr_cnt beats a new match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y      <= 1'b0;
            sticky <= 1'b0;
        end else begin
            y <= hit;
            if (clr_cnt)
                sticky <= 1'b0;
            else if (hit)
                sticky <= 1'b1;
        end
    end

    iiitb_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hit),
        .clr   (clr_cnt),
        .cnt   (match_cnt)
    );

    assign busy = (fill != FILL_FULL);

endmodule

// File: tb/tb_iiitb_sdm_param.sv
// Directed bench for iiitb_sdm_param: expected y per step goes through a
// scoreboard queue; counter/flag/busy are checked at chosen points.
module tb_iiitb_sdm_param;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             din = 1'b0;
    logic             din_vld = 1'b0;
    logic             pat_ld = 1'b0;
    logic [PAT_W-1:0] pat_in = '0;
    logic [PAT_W-1:0] mask_in = '0;
    logic             overlap = 1'b1;
    logic             clr_cnt = 1'b0;
    logic             y;
    logic [CNT_W-1:0] match_cnt;
    logic             sticky;
    logic             busy;

    int n_assert = 0;
    int n_fail   = 0;
    logic exp_q[$];

    iiitb_sdm_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_vld   (din_vld),
        .pat_ld    (pat_ld),
        .pat_in    (pat_in),
        .mask_in   (mask_in),
        .overlap   (overlap),
        .clr_cnt   (clr_cnt),
        .y         (y),
        .match_cnt (match_cnt),
        .sticky    (sticky),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected y, compare after the edge.
    task automatic step(input logic d, input logic v, input logic ld, input logic clr,
                        input logic ey, input string tag);
        logic e;
        @(negedge clk);
        din     = d;
        din_vld = v;
        pat_ld  = ld;
        clr_cnt = clr;
        exp_q.push_back(ey);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, " queue"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " y"}, 32'(y), 32'(e));
        end
        din_vld = 1'b0;
        pat_ld  = 1'b0;
        clr_cnt = 1'b0;
    endtask

    // Feed n valid bits, MSB of bits first; ey holds the expected y per bit.
    task automatic run(input int n, input logic [15:0] bits, input logic [15:0] ey,
                       input string tag);
        for (int i = n - 1; i >= 0; i--)
            step(bits[i], 1'b1, 1'b0, 1'b0, ey[i], tag);
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] m);
        pat_in  = p;
        mask_in = m;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "load");
        chk("load busy", 32'(busy), 32'd1);
    endtask

    initial begin
        // Reset held with din toggling.
        for (int i = 0; i < 4; i++) begin
            #2.5 din = ~din;
        end
        chk("rst y", 32'(y), 32'd0);
        chk("rst cnt", 32'(match_cnt), 32'd0);
        chk("rst sticky", 32'(sticky), 32'd0);
        chk("rst busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Overlapping detection of 1010.
        overlap = 1'b1;
        run(11, 16'b01010100100, 16'b00001010000, "ovl");
        chk("ovl cnt", 32'(match_cnt), 32'd2);
        chk("ovl sticky", 32'(sticky), 32'd1);
        chk("ovl busy", 32'(busy), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "clr");
        chk("clr cnt", 32'(match_cnt), 32'd0);
        chk("clr sticky", 32'(sticky), 32'd0);

        // Non-overlapping: same stream from a fresh window.
        overlap = 1'b0;
        load(4'b1010, 4'b1111);
        run(5, 16'b01010, 16'b00001, "novl");
        chk("novl busy after hit", 32'(busy), 32'd1);
        run(3, 16'b100, 16'b000, "novl");
        chk("novl busy 3 bits", 32'(busy), 32'd1);
        run(1, 16'b1, 16'b0, "novl");
        chk("novl busy full", 32'(busy), 32'd0);
        run(2, 16'b00, 16'b00, "novl");
        chk("novl cnt", 32'(match_cnt), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "clr");

        // Valid gaps are transparent.
        overlap = 1'b1;
        load(4'b1010, 4'b1111);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "gap");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "gap");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "gap");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gap");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "gap");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "gap");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "gap");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "gap hold");
        chk("gap cnt", 32'(match_cnt), 32'd1);

        // Reload to 0110 with a valid bit that must be ignored.
        load(4'b0110, 4'b1111);
        run(3, 16'b011, 16'b000, "rld");
        chk("rld busy", 32'(busy), 32'd1);
        run(1, 16'b0, 16'b1, "rld");
        chk("rld cnt", 32'(match_cnt), 32'd2);

        // Masked compare and counter saturation.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "clr");
        load(4'b1001, 4'b1001);
        run(3, 16'b111, 16'b000, "sat");
        chk("sat cnt0", 32'(match_cnt), 32'd0);
        run(3, 16'b111, 16'b111, "sat");
        chk("sat cnt3", 32'(match_cnt), 32'd3);
        run(1, 16'b1, 16'b1, "sat");
        chk("sat hold", 32'(match_cnt), 32'd3);
        chk("sat sticky", 32'(sticky), 32'd1);

        // clr_cnt collides with a completing bit.
        load(4'b1010, 4'b1111);
        run(3, 16'b101, 16'b000, "col");
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "col");
        chk("col cnt", 32'(match_cnt), 32'd0);
        chk("col sticky", 32'(sticky), 32'd0);
        run(2, 16'b10, 16'b01, "col ovl");
        chk("col ovl cnt", 32'(match_cnt), 32'd1);

        // Async reset mid-pattern, then pattern reverts to 1010.
        load(4'b0110, 4'b1111);
        run(3, 16'b101, 16'b000, "mid");
        #2;
        reset = 1'b1;
        #1;
        chk("async y", 32'(y), 32'd0);
        chk("async cnt", 32'(match_cnt), 32'd0);
        chk("async sticky", 32'(sticky), 32'd0);
        chk("async busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        run(1, 16'b0, 16'b0, "post rst");
        run(4, 16'b1010, 16'b0001, "revert");
        chk("revert cnt", 32'(match_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/iiitb_sdm_param.md
Name: iiitb_sdm_param

Overview:
Parametrised successor to the fixed 1010 serial sequence detector. It detects a runtime-programmable, maskable bit pattern of up to PAT_W bits on a serial input, qualified by a valid strobe. Overlapping or non-overlapping matching is selectable. A saturating match counter and a sticky flag feed the status logic. It sits between the serial front end and the control/status block.

Parameters:
PAT_W, 4, pattern length in bits (2..32)
CNT_W, 8, match counter width
RST_PAT, 4'b1010, pattern loaded at reset (PAT_W bits)
RST_MASK, all ones, compare mask loaded at reset (1 = bit compared)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
din  in  1  serial data bit
din_vld  in  1  din sampled only when high
pat_ld  in  1  load pat_in/mask_in this cycle
pat_in  in  PAT_W  new pattern; bit PAT_W-1 = oldest bit
mask_in  in  PAT_W  new compare mask
overlap  in  1  1 = overlapping detection, 0 = non-overlapping
clr_cnt  in  1  synchronous clear of count and sticky
y  out  1  one-cycle match pulse (registered)
match_cnt  out  CNT_W  saturating number of matches
sticky  out  1  set on first match, held until clr_cnt/reset
busy  out  1  high while fill < PAT_W (window not yet full)

Behaviour:
- One clock: clk. Reset is asynchronous and active-high (reset). All state clears immediately on reset assertion.
- Reset values: y=0, match_cnt=0, sticky=0, busy=1, history=0, fill=0, pattern=RST_PAT, mask=RST_MASK.
- history: PAT_W-bit shift register. On din_vld it becomes {history[PAT_W-2:0], din}.
- fill: counter 0..PAT_W. It increments on each din_vld and saturates at PAT_W.
- Match condition, evaluated on the next-state values: din_vld && (fill_next == PAT_W) && ((history_next ^ pattern) & mask) == 0.
- y is registered and asserts the cycle after the clk edge that samples the completing bit. Latency from din sample to y is 1 clock. y is high for exactly 1 cycle per match.
- overlap=1: history and fill are untouched on match, so consecutive matches may share bits.
- overlap=0: on match, fill is forced to 0 and history is retained. The next match needs PAT_W fresh valid bits.
- din_vld=0: history, fill and y hold off, no match. Gaps in din_vld are transparent.
- pat_ld=1: pattern and mask load at the edge and fill clears to 0; any din_vld that cycle is ignored. pat_ld has priority over din_vld. No match is reported in that cycle.
- mask all zero: every valid bit after the window fills is a match. This is legal and is not guarded.
- Counter: +1 per match, holds at 2^CNT_W-1 (no wrap). clr_cnt has priority over a simultaneous increment: result is 0 and sticky=0. The y pulse still occurs.
- sticky: set with y, cleared only by clr_cnt or reset.
- busy = (fill != PAT_W), combinational from the fill register.
- The overlap input may change at any time. It takes effect on the next match evaluation and needs no flush.
- Reset mid-stream: the partial window is discarded, and pattern/mask revert to the reset values.

Decomposition:
- Shared package iiitb_sdm_pkg holds:
  - default pattern constant SDM_PAT_1010
  - max PAT_W bound
  - mode constants SDM_MODE_OVERLAP=1, SDM_MODE_NONOVL=0
- One sub-module, iiitb_sat_cnt: parametrised CNT_W saturating counter with inc and sync clr (clr priority). It is reused by other status blocks.
- Window/compare logic stays in the top.

Test Plan:
- Reset defaults: hold reset 10 ns with din toggling -> y=0, match_cnt=0, sticky=0, busy=1; then deassert.
- Overlap, PAT 1010: overlap=1, din_vld=1 each cycle, stream 0,1,0,1,0,1,0,0,1,0,0 -> y pulses after the 5th and 7th bits; match_cnt=2, sticky=1.
- Non-overlap: same stream, overlap=0 -> single y pulse after the 5th bit, match_cnt=1. busy is re-asserted for 4 valid bits after the match.
- Valid gaps and reload: insert din_vld=0 cycles inside 1,0,1,0 -> one match, timing shifted by the gap count. Then pat_ld with pat_in=4'b0110, mask_in=4'b1111 during a bit -> fill=0, that bit ignored. Stream 0,1,1,0 -> y once.
- Mask and saturation: CNT_W=2, mask=4'b1001, pat=4'b1001, overlap=1, stream 1,1,1,1,1,1 -> y on bits 4,5,6; match_cnt saturates at 3.
- clr/inc collision and async reset: clr_cnt in the same cycle as a completing bit -> y=1, match_cnt=0, sticky=0. Assert reset mid-pattern (after 1,0,1) -> all outputs clear within the same time step; the following 0 does not match.
